// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute controller for the 8-bit CPU
// with its 9-bit instruction word. It fetches over a req/ready handshake,
// steers the register file and ALU, keeps a copy of the ALU flags, and steps
// or branches the PC.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | parked; leaves for FETCH once run_en is seen
// FETCH  | imem_req high, waiting for imem_ready (bounded wait)
// DECODE | IR decoded, read addresses presented for one cycle
// EXEC   | ALU op: flags captured; BZ: PC stepped or branched
// WB     | one-cycle register-file write of rd, PC stepped
// HALT   | terminal, HALT instruction executed
// FAULT  | terminal, instruction memory never answered
//
// Instruction word: [8:6] opcode, [5:3] rd, [2:0] rs, [5:0] signed imm6.

module cpu_sequencer #(
    parameter logic [7:0] RESET_PC      = 8'h00,
    parameter int         FETCH_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_en,
    output logic       imem_req,
    input  logic       imem_ready,
    input  logic [8:0] instr,
    output logic [7:0] pc_out,
    output logic [2:0] rf_raddr_a,
    output logic [2:0] rf_raddr_b,
    output logic       rf_we,
    output logic [2:0] rf_waddr,
    output logic [2:0] alu_op,
    input  logic [3:0] flags_in,
    output logic [3:0] flags_q,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [2:0] OP_BZ  = 3'b110;
    localparam logic [2:0] OP_SYS = 3'b111;

    // Terminal count for the fetch wait; legal values are 1..255.
    localparam logic [7:0] FETCH_TC = 8'(FETCH_TIMEOUT);

    // Flag bit positions inside {C,Z,N,V}.
    localparam int FLAG_Z = 2;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] pc_q;
    logic [7:0] pc_d;
    logic [8:0] ir_q;
    logic [8:0] ir_d;
    logic [3:0] flags_d;
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;

    logic [2:0] ir_op;
    logic [2:0] ir_rd;
    logic [2:0] ir_rs;
    logic [7:0] ir_imm_sext;
    logic [7:0] pc_inc;
    logic [7:0] wait_cnt_inc;

    assign ir_op        = ir_q[8:6];
    assign ir_rd        = ir_q[5:3];
    assign ir_rs        = ir_q[2:0];
    assign ir_imm_sext  = {{2{ir_q[5]}}, ir_q[5:0]};
    assign pc_inc       = pc_q + 8'd1;
    assign wait_cnt_inc = wait_cnt_q + 8'd1;

    // State register plus the PC, IR, flag copy and fetch-wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 9'd0;
            flags_q    <= 4'd0;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            flags_q    <= flags_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state and next-datapath decisions.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        flags_d    = flags_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                wait_cnt_d = 8'd0;
                if (run_en) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                if (imem_ready) begin
                    ir_d       = instr;
                    wait_cnt_d = 8'd0;
                    state_d    = S_DECODE;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (wait_cnt_inc == FETCH_TC) begin
                        state_d = S_FAULT;
                    end
                end
            end

            S_DECODE: begin
                if (ir_op == OP_SYS) begin
                    if (ir_q[0]) begin
                        state_d = S_HALT;
                    end else begin
                        // NOP retires here without touching the datapath.
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (ir_op == OP_BZ) begin
                    // Branch uses the flags from the previous ALU op, not flags_in.
                    if (flags_q[FLAG_Z]) begin
                        pc_d = pc_q + ir_imm_sext;
                    end else begin
                        pc_d = pc_inc;
                    end
                    state_d = S_FETCH;
                end else begin
                    flags_d = flags_in;
                    state_d = S_WB;
                end
            end

            S_WB: begin
                pc_d    = pc_inc;
                state_d = run_en ? S_FETCH : S_IDLE;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state and IR only.
    always_comb begin
        imem_req   = 1'b0;
        rf_raddr_a = 3'd0;
        rf_raddr_b = 3'd0;
        rf_we      = 1'b0;
        rf_waddr   = 3'd0;
        alu_op     = 3'd0;
        halted     = 1'b0;
        fault      = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
            end

            S_DECODE: begin
                rf_raddr_a = ir_rd;
                rf_raddr_b = ir_rs;
            end

            S_EXEC: begin
                if (ir_op != OP_BZ) begin
                    rf_raddr_a = ir_rd;
                    rf_raddr_b = ir_rs;
                    alu_op     = ir_op;
                end
            end

            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = ir_rd;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            S_FAULT: begin
                fault = 1'b1;
            end

            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign pc_out    = pc_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus a random instruction
// stream, each instruction checked cycle by cycle against a per-instruction
// model of PC, flags and expected state walk.

module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run_en = 1'b0;
    logic       imem_ready = 1'b0;
    logic [8:0] instr = 9'd0;
    logic [3:0] flags_in = 4'd0;

    logic       imem_req;
    logic [7:0] pc_out;
    logic [2:0] rf_raddr_a;
    logic [2:0] rf_raddr_b;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [2:0] alu_op;
    logic [3:0] flags_q;
    logic       halted;
    logic       fault;
    logic [2:0] state_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_pc;
    logic [3:0] m_flags;

    cpu_sequencer #(.RESET_PC(8'h00), .FETCH_TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .run_en     (run_en),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .instr      (instr),
        .pc_out     (pc_out),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .alu_op     (alu_op),
        .flags_in   (flags_in),
        .flags_q    (flags_q),
        .halted     (halted),
        .fault      (fault),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        run_en = 1'b0;
        imem_ready = 1'b0;
        flags_in = 4'd0;
        #1;
        checks++;
        if ({state_out, pc_out, flags_q, halted, fault, imem_req, rf_we} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state st=%0d pc=%02h fl=%h h=%b f=%b req=%b we=%b expected all zero",
                     state_out, pc_out, flags_q, halted, fault, imem_req, rf_we);
        end
        m_pc = 8'h00;
        m_flags = 4'h0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic start_run();
        run_en = 1'b1;
        @(negedge clk);
    endtask

    // Entry: at a negedge with the DUT in FETCH. Exit: same, one instruction later
    // (except HALT, which leaves the DUT parked in HALT).
    task automatic run_instr(input logic [8:0] ins, input int stall, input logic [3:0] fl,
                             input logic wb_run, input logic jitter);
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        int         off;
        op = ins[8:6];
        rd = ins[5:3];
        rs = ins[2:0];

        for (int i = 0; i <= stall; i++) begin
            checks++;
            if (state_out !== 3'd1 || imem_req !== 1'b1 || pc_out !== m_pc || rf_we !== 1'b0 ||
                fault !== 1'b0 || flags_q !== m_flags) begin
                errors++;
                $display("FAIL fetch ins=%h cyc=%0d st=%0d req=%b pc=%02h we=%b f=%b fl=%h expected st=1 req=1 pc=%02h we=0 f=0 fl=%h",
                         ins, i, state_out, imem_req, pc_out, rf_we, fault, flags_q, m_pc, m_flags);
            end
            imem_ready = (i == stall);
            instr = (i == stall) ? ins : 9'($urandom);
            if (jitter) run_en = 1'($urandom);
            @(negedge clk);
        end

        checks++;
        if (state_out !== 3'd2 || rf_raddr_a !== rd || rf_raddr_b !== rs || rf_we !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL decode ins=%h st=%0d ra=%0d rb=%0d we=%b req=%b expected st=2 ra=%0d rb=%0d we=0 req=0",
                     ins, state_out, rf_raddr_a, rf_raddr_b, rf_we, imem_req, rd, rs);
        end
        imem_ready = 1'($urandom);
        instr = 9'($urandom);
        if (jitter) run_en = 1'($urandom);
        @(negedge clk);

        if (op == 3'b111 && ins[0]) begin
            checks++;
            if (state_out !== 3'd5 || halted !== 1'b1 || pc_out !== m_pc) begin
                errors++;
                $display("FAIL halt_entry st=%0d h=%b pc=%02h expected st=5 h=1 pc=%02h",
                         state_out, halted, pc_out, m_pc);
            end
            return;
        end
        if (op == 3'b111) begin
            m_pc = m_pc + 8'd1;
            return;
        end

        checks++;
        if (state_out !== 3'd3 || rf_we !== 1'b0 ||
            (op != 3'b110 && (alu_op !== op || rf_raddr_a !== rd || rf_raddr_b !== rs))) begin
            errors++;
            $display("FAIL exec ins=%h st=%0d we=%b op=%0d ra=%0d rb=%0d expected st=3 we=0 op=%0d ra=%0d rb=%0d",
                     ins, state_out, rf_we, alu_op, rf_raddr_a, rf_raddr_b, op, rd, rs);
        end
        flags_in = fl;
        imem_ready = 1'($urandom);
        if (jitter) run_en = 1'($urandom);
        @(negedge clk);

        if (op == 3'b110) begin
            if (m_flags[2]) begin
                off = (ins[5:0] >= 6'd32) ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
                m_pc = 8'((int'(m_pc) + off + 256) % 256);
            end else begin
                m_pc = m_pc + 8'd1;
            end
            return;
        end

        m_flags = fl;
        checks++;
        if (state_out !== 3'd4 || rf_we !== 1'b1 || rf_waddr !== rd || flags_q !== m_flags || pc_out !== m_pc) begin
            errors++;
            $display("FAIL wb ins=%h st=%0d we=%b wa=%0d fl=%h pc=%02h expected st=4 we=1 wa=%0d fl=%h pc=%02h",
                     ins, state_out, rf_we, rf_waddr, flags_q, pc_out, rd, m_flags, m_pc);
        end
        run_en = wb_run;
        flags_in = 4'($urandom);
        @(negedge clk);
        m_pc = m_pc + 8'd1;

        if (!wb_run) begin
            checks++;
            if (state_out !== 3'd0 || pc_out !== m_pc || rf_we !== 1'b0) begin
                errors++;
                $display("FAIL wb_to_idle st=%0d pc=%02h we=%b expected st=0 pc=%02h we=0",
                         state_out, pc_out, rf_we, m_pc);
            end
            run_en = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        run_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (state_out !== 3'd0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold st=%0d req=%b expected st=0 req=0", state_out, imem_req);
        end
    endtask

    task automatic test_add_sequence();
        do_reset();
        start_run();
        run_instr(9'b000_001_010, 0, 4'h0, 1'b1, 1'b0);
        checks++;
        if (state_out !== 3'd1 || pc_out !== 8'h01) begin
            errors++;
            $display("FAIL add_done st=%0d pc=%02h expected st=1 pc=01", state_out, pc_out);
        end
    endtask

    task automatic test_fetch_stall();
        run_instr(9'b011_110_101, 3, 4'h3, 1'b1, 1'b0);
        checks++;
        if (pc_out !== 8'h02 || fault !== 1'b0) begin
            errors++;
            $display("FAIL stall_done pc=%02h f=%b expected pc=02 f=0", pc_out, fault);
        end
    endtask

    task automatic test_branch_wrap();
        do_reset();
        start_run();
        run_instr(9'b001_000_000, 0, 4'b0100, 1'b1, 1'b0);
        run_instr({3'b110, 6'h3E}, 0, 4'h0, 1'b1, 1'b0);
        checks++;
        if (pc_out !== 8'hFF || state_out !== 3'd1) begin
            errors++;
            $display("FAIL bz_taken pc=%02h st=%0d expected pc=ff st=1", pc_out, state_out);
        end

        do_reset();
        start_run();
        run_instr(9'b000_010_011, 0, 4'b0100, 1'b1, 1'b0);
        run_instr({3'b110, 6'h3D}, 0, 4'h0, 1'b1, 1'b0);
        run_instr(9'b100_001_001, 0, 4'b1001, 1'b1, 1'b0);
        checks++;
        if (pc_out !== 8'hFF) begin
            errors++;
            $display("FAIL pc_setup pc=%02h expected ff", pc_out);
        end
        run_instr({3'b110, 6'h3E}, 1, 4'h0, 1'b1, 1'b0);
        checks++;
        if (pc_out !== 8'h00 || flags_q !== 4'b1001) begin
            errors++;
            $display("FAIL bz_not_taken_wrap pc=%02h fl=%h expected pc=00 fl=9", pc_out, flags_q);
        end
    endtask

    task automatic test_halt();
        do_reset();
        start_run();
        repeat (5) run_instr(9'b111_000_000, 0, 4'h0, 1'b1, 1'b0);
        run_instr(9'b111_000_001, 0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_en = 1'($urandom);
            imem_ready = 1'($urandom);
            @(negedge clk);
            checks++;
            if (state_out !== 3'd5 || halted !== 1'b1 || pc_out !== 8'h05 || imem_req !== 1'b0 || rf_we !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold st=%0d h=%b pc=%02h req=%b we=%b expected st=5 h=1 pc=05 req=0 we=0",
                         state_out, halted, pc_out, imem_req, rf_we);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        start_run();
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (state_out !== 3'd1 || fault !== 1'b0 || imem_req !== 1'b1) begin
                errors++;
                $display("FAIL timeout_wait cyc=%0d st=%0d f=%b req=%b expected st=1 f=0 req=1",
                         i, state_out, fault, imem_req);
            end
            imem_ready = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (state_out !== 3'd6 || fault !== 1'b1 || pc_out !== 8'h00 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fault st=%0d f=%b pc=%02h req=%b expected st=6 f=1 pc=00 req=0",
                     state_out, fault, pc_out, imem_req);
        end
        for (int i = 0; i < 5; i++) begin
            imem_ready = 1'b1;
            instr = 9'($urandom);
            run_en = 1'($urandom);
            @(negedge clk);
            checks++;
            if (state_out !== 3'd6 || fault !== 1'b1 || pc_out !== 8'h00) begin
                errors++;
                $display("FAIL fault_hold st=%0d f=%b pc=%02h expected st=6 f=1 pc=00",
                         state_out, fault, pc_out);
            end
        end
    endtask

    task automatic test_reset_mid_wb();
        do_reset();
        start_run();
        run_instr(9'b000_000_001, 0, 4'h0, 1'b1, 1'b0);
        imem_ready = 1'b1;
        instr = 9'b010_011_101;
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        flags_in = 4'hA;
        @(negedge clk);
        checks++;
        if (state_out !== 3'd4 || rf_we !== 1'b1 || flags_q !== 4'hA) begin
            errors++;
            $display("FAIL pre_reset_wb st=%0d we=%b fl=%h expected st=4 we=1 fl=a", state_out, rf_we, flags_q);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || state_out !== 3'd0 || pc_out !== 8'h00 || flags_q !== 4'h0) begin
            errors++;
            $display("FAIL async_reset_wb we=%b st=%0d pc=%02h fl=%h expected we=0 st=0 pc=00 fl=0",
                     rf_we, state_out, pc_out, flags_q);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || state_out !== 3'd0) begin
            errors++;
            $display("FAIL reset_held we=%b st=%0d expected we=0 st=0", rf_we, state_out);
        end
        reset = 1'b1;
        m_pc = 8'h00;
        m_flags = 4'h0;
    endtask

    task automatic test_random_stream();
        logic [8:0] ins;
        do_reset();
        start_run();
        for (int n = 0; n < 300; n++) begin
            ins = 9'($urandom);
            if (ins[8:6] == 3'b111) ins[0] = 1'b0;
            run_instr(ins, int'($urandom_range(0, 5)), 4'($urandom),
                      ($urandom_range(0, 3) != 0), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_add_sequence();
        test_fetch_stall();
        test_branch_wrap();
        test_halt();
        test_timeout();
        test_reset_mid_wb();
        test_random_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control sequencer for the 8-bit CPU with its 9-bit instruction format.
- Fetches an instruction from instruction memory over a req/ready handshake, then decodes it.
- Drives register-file read/write addresses and the ALU opcode, captures the ALU flags, and advances or branches the PC.
- Sits between the instruction memory, the register file and the ALU, replacing fixed single-cycle PC stepping.

Parameters:
- RESET_PC, 8'h00: PC value loaded on reset.
- FETCH_TIMEOUT, 15: maximum cycles FETCH waits for imem_ready before FAULT; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- run_en  in  1  allows leaving IDLE.
- imem_req  out  1  fetch request to instruction memory.
- imem_ready  in  1  instruction valid this cycle.
- instr  in  9  instruction word from instruction memory.
- pc_out  out  8  current PC; this is the fetch address.
- rf_raddr_a  out  3  register-file read port A address (rd).
- rf_raddr_b  out  3  register-file read port B address (rs).
- rf_we  out  1  register-file write enable.
- rf_waddr  out  3  register-file write address.
- alu_op  out  3  ALU operation select.
- flags_in  in  4  ALU flags {C,Z,N,V}.
- flags_q  out  4  registered flags.
- halted  out  1  HALT state reached.
- fault  out  1  fetch timeout occurred.
- state_out  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5, FAULT=6.

Behaviour:
- Instruction decode:
  - opcode = instr[8:6]; rd = instr[5:3]; rs = instr[2:0]; imm6 = instr[5:0], signed.
  - 000..101: ALU ops ADD, SUB, AND, OR, XOR, SHL, computing rd <= rd op rs.
  - 110: BZ, branch if flags_q Z bit set.
  - 111: HALT if instr[0]=1, otherwise NOP.
- Reset (reset=0, asynchronous):
  - state=IDLE, pc_out=RESET_PC, IR=0, flags_q=0, timeout counter=0.
  - All strobes 0; halted=0, fault=0.
  - Applies from any state, including mid-fetch and mid-write-back. A write-back in progress is dropped with no rf_we pulse.
- IDLE: go to FETCH the cycle after run_en=1; otherwise stay.
- FETCH:
  - imem_req=1 while in FETCH.
  - On imem_ready=1: IR<=instr, counter cleared, next=DECODE.
  - Otherwise the counter increments; when it reaches FETCH_TIMEOUT, next=FAULT.
  - imem_ready while not in FETCH is ignored.
- DECODE: rf_raddr_a=rd, rf_raddr_b=rs, valid for one cycle; next=EXEC.
  - HALT encoding -> next=HALT, PC unchanged.
  - NOP -> pc+1, next=FETCH.
- EXEC:
  - ALU op: alu_op=opcode, read addresses still held; flags_q<=flags_in; next=WB.
  - BZ:
    - If flags_q[2] (Z)=1: pc <= pc + sign_extend(imm6), modulo 256 (0x02 + 0x3E(-2) = 0x00; 0xFF + 1 = 0x00).
    - Otherwise pc <= pc+1.
    - next=FETCH; flags_q unchanged; no write-back.
- WB:
  - rf_we=1 and rf_waddr=rd for exactly one cycle.
  - pc <= pc+1, wrapping 0xFF -> 0x00; next=FETCH, or IDLE if run_en=0.
- HALT and FAULT:
  - Terminal states; exit only by reset.
  - halted=1 or fault=1 respectively, asserted the cycle the state is entered.
  - All strobes 0; pc_out frozen.
- Latency, with imem_ready on the first FETCH cycle:
  - ALU instruction = 4 cycles (FETCH, DECODE, EXEC, WB).
  - BZ = 3 cycles; NOP = 2 cycles.
  - Each FETCH wait cycle adds one cycle.
- Outputs are registered or decoded from the registered state only; there is no combinational path from imem_ready to imem_req.
- run_en=0 mid-instruction does not abort; it only takes effect at the WB -> IDLE decision and in IDLE.

Test Plan:
- Reset sequence: reset=0, release, run_en=1, imem_ready tied 1, program ADD r1,r2 (9'b000_001_010) -> states 1,2,3,4,1. rf_we high only in WB with rf_waddr=1; pc_out 0 -> 1.
- Fetch stall: imem_ready held 0 for 3 cycles, then 1 -> imem_req high for 4 cycles; state stays 1, then moves to 2; no fault.
- Timeout: imem_ready held 0 with FETCH_TIMEOUT=15 -> fault=1, state=6 after 15 FETCH cycles. pc_out frozen; nothing further until reset=0.
- Branch taken and wrap:
  - SUB r0,r0 sets Z=1, then BZ imm6=6'h3E at pc=1 -> pc_out becomes 0xFF, with no rf_we in the BZ sequence.
  - Separately, at pc=0xFF, BZ with Z=0 -> pc_out=0x00.
- HALT: 9'b111_000_001 at pc=5 -> halted=1 after DECODE, pc_out stays 5. run_en toggling has no effect.
- Async reset mid-WB: assert reset=0 between clock edges during WB -> rf_we drops immediately, state=0, pc_out=RESET_PC, flags_q=0.
